irq_priority_ctl: RTL and testbench

Registered, masked interrupt priority controller for the 16-bit Synapse peripheral bus. It latches edge- or level-type request lines, applies a software-written enable mask, and presents the most urgent pending request as a 16-bit code. The code stays frozen under a valid/ack handshake until the core acknowledges it. It sits between peripheral IRQ sources and the core's interrupt vector logic. It supersedes the purely combinational encoder: it adds latching, masking, a per-input mode and a stable handshake.

---
 rtl/irq_priority_pkg.sv | 25 ++
 rtl/irq_priority_ctl_prio_select.sv | 28 ++
 rtl/irq_priority_ctl.sv | 145 ++++++++++++++
 tb/tb_irq_priority_ctl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/irq_priority_pkg.sv
// ---------------------------------------------------------------------------
// irq_priority_pkg
// Shared types and constants for the interrupt priority controller.
//   state_t     : presentation FSM states (IDLE, PRESENT, HOLDOFF)
//   IRQ_CODE_W  : width of the externally visible interrupt code
//   code_w()    : internal code width for a given number of request lines
// ---------------------------------------------------------------------------
package irq_priority_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESENT = 2'd1,
        HOLDOFF = 2'd2
    } state_t;

    localparam int IRQ_CODE_W = 16;

    // Index width needed to name every request line, never less than one bit.
    function automatic int code_w(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/irq_priority_ctl_prio_select.sv
// ---------------------------------------------------------------------------
// prio_select
// Combinational highest-set-bit finder. The highest index wins.
//   req  in  NUM_INPUTS : candidate vector (pending & mask)
//   idx  out CODE_W     : index of the highest set bit (0 when none set)
//   any  out 1          : at least one bit of req is set
// ---------------------------------------------------------------------------
module prio_select #(
    parameter int NUM_INPUTS = 16,
    parameter int CODE_W     = 4
) (
    input  logic [NUM_INPUTS-1:0] req,
    output logic [CODE_W-1:0]     idx,
    output logic                  any
);

    // Ascending scan: a later (higher) set bit overwrites an earlier one.
    always_comb begin
        any = |req;
        idx = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (req[i]) begin
                idx = CODE_W'(i);
            end
        end
    end

endmodule

// File: rtl/irq_priority_ctl.sv
// ---------------------------------------------------------------------------
// irq_priority_ctl
// Registered, masked interrupt priority controller. Latches edge- or
// level-type request lines, gates them with a software enable mask and
// presents the highest-index enabled pending request, frozen under a
// valid/ack handshake.
//   sysclk     in  1          : clock, all state changes on its rising edge
//   sysreset   in  1          : synchronous active-high reset
//   irq_in     in  NUM_INPUTS : request lines
//   mask_wr    in  1          : strobe loading mask_data into the enable mask
//   mask_data  in  NUM_INPUTS : new enable mask
//   irq_ack    in  1          : acknowledges the presented code
//   irq_valid  out 1          : a code is being presented
//   irq_code   out 16         : index of the presented input, zero-extended
//   pending    out NUM_INPUTS : raw pending vector
// ---------------------------------------------------------------------------
module irq_priority_ctl
    import irq_priority_pkg::*;
#(
    parameter int                    NUM_INPUTS = 16,
    parameter logic [NUM_INPUTS-1:0] EDGE_MASK  = '1,
    parameter logic [NUM_INPUTS-1:0] RESET_MASK = '0
) (
    input  logic                  sysclk,
    input  logic                  sysreset,
    input  logic [NUM_INPUTS-1:0] irq_in,
    input  logic                  mask_wr,
    input  logic [NUM_INPUTS-1:0] mask_data,
    input  logic                  irq_ack,
    output logic                  irq_valid,
    output logic [IRQ_CODE_W-1:0] irq_code,
    output logic [NUM_INPUTS-1:0] pending
);

    localparam int CODE_W = code_w(NUM_INPUTS);

    logic [NUM_INPUTS-1:0] irq_prev_p0;
    logic [NUM_INPUTS-1:0] pend_q;
    logic [NUM_INPUTS-1:0] mask_q;
    logic [NUM_INPUTS-1:0] rise;
    logic [NUM_INPUTS-1:0] ack_clr;
    logic [NUM_INPUTS-1:0] pend_nxt;
    logic [NUM_INPUTS-1:0] sel_req;

    state_t                state;
    state_t                state_nxt;
    logic                  valid_q;
    logic                  valid_nxt;
    logic [CODE_W-1:0]     code_q;
    logic [CODE_W-1:0]     code_nxt;
    logic [CODE_W-1:0]     sel_idx;
    logic                  sel_any;
    logic                  ack_take;

    assign rise    = irq_in & ~irq_prev_p0;
    assign sel_req = pend_q & mask_q;

    prio_select #(
        .NUM_INPUTS (NUM_INPUTS),
        .CODE_W     (CODE_W)
    ) u_prio_select (
        .req (sel_req),
        .idx (sel_idx),
        .any (sel_any)
    );

    // One-hot clear of the acknowledged bit.
    always_comb begin
        ack_clr = '0;
        if (ack_take) begin
            ack_clr[code_q] = 1'b1;
        end
    end

    // Edge bits: clear on ack, then OR in the new edge so a same-cycle
    // edge survives the clear. Level bits simply track the sampled line.
    assign pend_nxt = (EDGE_MASK & ((pend_q & ~ack_clr) | rise))
                    | (~EDGE_MASK & irq_in);

    // Next-state and output logic
    always_comb begin
        state_nxt = state;
        valid_nxt = valid_q;
        code_nxt  = code_q;
        ack_take  = 1'b0;
        case (state)
            IDLE: begin
                if (sel_any) begin
                    state_nxt = PRESENT;
                    valid_nxt = 1'b1;
                    code_nxt  = sel_idx;
                end
            end
            PRESENT: begin
                // Code stays frozen regardless of new arrivals or mask writes.
                if (irq_ack) begin
                    ack_take  = 1'b1;
                    valid_nxt = 1'b0;
                    state_nxt = HOLDOFF;
                end
            end
            HOLDOFF: begin
                // Lets the post-ack pending vector settle before reselection.
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                valid_nxt = 1'b0;
            end
        endcase
    end

    // State register
    always_ff @(posedge sysclk) begin
        if (sysreset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Sampling / pending / mask / output registers
    always_ff @(posedge sysclk) begin
        // Loaded even in reset so a line held high through reset is no edge.
        irq_prev_p0 <= irq_in;
        if (sysreset) begin
            valid_q <= 1'b0;
            code_q  <= '0;
            pend_q  <= '0;
            mask_q  <= RESET_MASK;
        end else begin
            valid_q <= valid_nxt;
            code_q  <= code_nxt;
            pend_q  <= pend_nxt;
            if (mask_wr) begin
                mask_q <= mask_data;
            end
        end
    end

    assign irq_valid = valid_q;
    assign irq_code  = IRQ_CODE_W'(code_q);
    assign pending   = pend_q;

endmodule

// File: tb/tb_irq_priority_ctl.sv
// ---------------------------------------------------------------------------
// tb_irq_priority_ctl
// Table-driven bench for irq_priority_ctl (16 inputs, input 4 level mode).
// Each row gives the inputs sampled at one rising edge and the outputs
// expected just after that edge.
// ---------------------------------------------------------------------------
module tb_irq_priority_ctl;

    logic        sysclk = 1'b0;
    logic        sysreset;
    logic [15:0] irq_in;
    logic        mask_wr;
    logic [15:0] mask_data;
    logic        irq_ack;
    logic        irq_valid;
    logic [15:0] irq_code;
    logic [15:0] pending;

    always #5 sysclk = ~sysclk;

    irq_priority_ctl #(
        .NUM_INPUTS (16),
        .EDGE_MASK  (16'hFFEF),
        .RESET_MASK (16'h0000)
    ) dut (
        .sysclk    (sysclk),
        .sysreset  (sysreset),
        .irq_in    (irq_in),
        .mask_wr   (mask_wr),
        .mask_data (mask_data),
        .irq_ack   (irq_ack),
        .irq_valid (irq_valid),
        .irq_code  (irq_code),
        .pending   (pending)
    );

    typedef struct {
        logic        rst;
        logic [15:0] irq;
        logic        mwr;
        logic [15:0] mdat;
        logic        ack;
        logic        ev;
        logic [15:0] ec;
        logic        pm;
        logic [15:0] ep;
    } vec_t;

    typedef struct {
        int          id;
        logic        ev;
        logic [15:0] ec;
        logic        pm;
        logic [15:0] ep;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic add(input logic rst, input logic [15:0] irq, input logic mwr,
                       input logic [15:0] mdat, input logic ack, input logic ev,
                       input logic [15:0] ec, input logic pm, input logic [15:0] ep);
        vec_t v;
        v.rst = rst; v.irq = irq; v.mwr = mwr; v.mdat = mdat; v.ack = ack;
        v.ev = ev; v.ec = ec; v.pm = pm; v.ep = ep;
        tbl.push_back(v);
    endtask

    task automatic check16(input string nm, input int id, input logic [15:0] act,
                           input logic [15:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s step %0d: got %h, required %h", nm, id, act, req);
        end
    endtask

    task automatic step(input vec_t v, input int id);
        exp_t e;
        sysreset  = v.rst;
        irq_in    = v.irq;
        mask_wr   = v.mwr;
        mask_data = v.mdat;
        irq_ack   = v.ack;
        e.id = id; e.ev = v.ev; e.ec = v.ec; e.pm = v.pm; e.ep = v.ep;
        sb.push_back(e);
        @(posedge sysclk);
        #1;
        e = sb.pop_front();
        check16("irq_valid", e.id, {15'd0, irq_valid}, {15'd0, e.ev});
        if (e.ev) check16("irq_code", e.id, irq_code, e.ec);
        if (e.pm) check16("pending", e.id, pending, e.ep);
    endtask

    // Waits (bounded) for irq_valid; returns cycles waited, -1 on timeout.
    task automatic wait_valid(output int cycles);
        cycles = -1;
        for (int i = 1; i <= 10; i++) begin
            @(posedge sysclk);
            #1;
            if (irq_valid) begin
                cycles = i;
                break;
            end
        end
    endtask

    initial begin
        int cyc;
        sysreset = 1'b1; irq_in = '0; mask_wr = 1'b0; mask_data = '0; irq_ack = 1'b0;

        //  rst irq      mwr mdat     ack ev ec     pm ep
        // Reset with input 0 held high: no edge; re-rise presents code 0.
        add(1, 16'h0001, 0, 16'h0000, 0, 0, 16'd0,  1, 16'h0000);
        add(1, 16'h0001, 0, 16'h0000, 0, 0, 16'd0,  1, 16'h0000);
        add(0, 16'h0001, 1, 16'hFFFF, 0, 0, 16'd0,  1, 16'h0000);
        add(0, 16'h0001, 0, 16'h0000, 0, 0, 16'd0,  1, 16'h0000);
        add(0, 16'h0000, 0, 16'h0000, 0, 0, 16'd0,  1, 16'h0000);
        add(0, 16'h0001, 0, 16'h0000, 0, 0, 16'd0,  1, 16'h0001);
        add(0, 16'h0001, 0, 16'h0000, 0, 1, 16'd0,  1, 16'h0001);
        add(0, 16'h0000, 0, 16'h0000, 1, 0, 16'd0,  1, 16'h0000);
        add(0, 16'h0000, 0, 16'h0000, 0, 0, 16'd0,  0, 16'h0000);
        add(0, 16'h0000, 0, 16'h0000, 0, 0, 16'd0,  0, 16'h0000);
        // Simultaneous edges on 3 and 9.
        add(0, 16'h0208, 0, 16'h0000, 0, 0, 16'd0,  1, 16'h0208);
        add(0, 16'h0000, 0, 16'h0000, 0, 1, 16'd9,  1, 16'h0208);
        add(0, 16'h0000, 0, 16'h0000, 1, 0, 16'd0,  1, 16'h0008);
        add(0, 16'h0000, 0, 16'h0000, 0, 0, 16'd0,  0, 16'h0000);
        add(0, 16'h0000, 0, 16'h0000, 0, 1, 16'd3,  1, 16'h0008);
        add(0, 16'h0000, 0, 16'h0000, 1, 0, 16'd0,  1, 16'h0000);
        add(0, 16'h0000, 0, 16'h0000, 0, 0, 16'd0,  1, 16'h0000);
        add(0, 16'h0000, 0, 16'h0000, 0, 0, 16'd0,  1, 16'h0000);
        // Edge on 12 while 5 is presented: no pre-emption.
        add(0, 16'h0020, 0, 16'h0000, 0, 0, 16'd0,  1, 16'h0020);
        add(0, 16'h0000, 0, 16'h0000, 0, 1, 16'd5,  0, 16'h0000);
        add(0, 16'h1000, 0, 16'h0000, 0, 1, 16'd5,  1, 16'h1020);
        add(0, 16'h0000, 0, 16'h0000, 0, 1, 16'd5,  0, 16'h0000);
        add(0, 16'h0000, 0, 16'h0000, 1, 0, 16'd0,  1, 16'h1000);
        add(0, 16'h0000, 0, 16'h0000, 0, 0, 16'd0,  0, 16'h0000);
        add(0, 16'h0000, 0, 16'h0000, 0, 1, 16'd12, 0, 16'h0000);
        add(0, 16'h0000, 0, 16'h0000, 1, 0, 16'd0,  1, 16'h0000);
        add(0, 16'h0000, 0, 16'h0000, 0, 0, 16'd0,  0, 16'h0000);
        add(0, 16'h0000, 0, 16'h0000, 0, 0, 16'd0,  0, 16'h0000);
        // Input 7 masked: latches but is not presented until unmasked.
        add(0, 16'h0000, 1, 16'hFF7F, 0, 0, 16'd0,  0, 16'h0000);
        add(0, 16'h0080, 0, 16'h0000, 0, 0, 16'd0,  1, 16'h0080);
        add(0, 16'h0000, 0, 16'h0000, 0, 0, 16'd0,  1, 16'h0080);
        add(0, 16'h0000, 0, 16'h0000, 0, 0, 16'd0,  0, 16'h0000);
        add(0, 16'h0000, 1, 16'h0080, 0, 0, 16'd0,  0, 16'h0000);
        add(0, 16'h0000, 0, 16'h0000, 0, 1, 16'd7,  0, 16'h0000);
        add(0, 16'h0000, 0, 16'h0000, 1, 0, 16'd0,  1, 16'h0000);
        add(0, 16'h0000, 1, 16'hFFFF, 0, 0, 16'd0,  0, 16'h0000);
        add(0, 16'h0000, 0, 16'h0000, 0, 0, 16'd0,  0, 16'h0000);
        // Level input 4: re-presented while held, gone once deasserted.
        add(0, 16'h0010, 0, 16'h0000, 0, 0, 16'd0,  1, 16'h0010);
        add(0, 16'h0010, 0, 16'h0000, 0, 1, 16'd4,  0, 16'h0000);
        add(0, 16'h0010, 0, 16'h0000, 1, 0, 16'd0,  1, 16'h0010);
        add(0, 16'h0010, 0, 16'h0000, 0, 0, 16'd0,  0, 16'h0000);
        add(0, 16'h0010, 0, 16'h0000, 0, 1, 16'd4,  0, 16'h0000);
        add(0, 16'h0000, 0, 16'h0000, 0, 1, 16'd4,  1, 16'h0000);
        add(0, 16'h0000, 0, 16'h0000, 1, 0, 16'd0,  1, 16'h0000);
        add(0, 16'h0000, 0, 16'h0000, 0, 0, 16'd0,  0, 16'h0000);
        add(0, 16'h0000, 0, 16'h0000, 0, 0, 16'd0,  0, 16'h0000);
        add(0, 16'h0000, 0, 16'h0000, 0, 0, 16'd0,  0, 16'h0000);
        // Ack of 2 together with a new edge on 2: set wins.
        add(0, 16'h0004, 0, 16'h0000, 0, 0, 16'd0,  1, 16'h0004);
        add(0, 16'h0000, 0, 16'h0000, 0, 1, 16'd2,  0, 16'h0000);
        add(0, 16'h0004, 0, 16'h0000, 1, 0, 16'd0,  1, 16'h0004);
        add(0, 16'h0004, 0, 16'h0000, 0, 0, 16'd0,  1, 16'h0004);
        add(0, 16'h0000, 0, 16'h0000, 0, 1, 16'd2,  0, 16'h0000);
        add(0, 16'h0000, 0, 16'h0000, 1, 0, 16'd0,  1, 16'h0000);
        add(0, 16'h0000, 0, 16'h0000, 0, 0, 16'd0,  0, 16'h0000);
        // Ack in IDLE is ignored.
        add(0, 16'h0040, 0, 16'h0000, 1, 0, 16'd0,  1, 16'h0040);
        add(0, 16'h0000, 0, 16'h0000, 1, 1, 16'd6,  1, 16'h0040);
        add(0, 16'h0000, 0, 16'h0000, 0, 1, 16'd6,  1, 16'h0040);
        // Reset mid-PRESENT; mask returns to RESET_MASK (all off).
        add(1, 16'h0000, 0, 16'h0000, 0, 0, 16'd0,  1, 16'h0000);
        add(0, 16'h0000, 0, 16'h0000, 0, 0, 16'd0,  1, 16'h0000);
        add(0, 16'h0001, 0, 16'h0000, 0, 0, 16'd0,  1, 16'h0001);
        add(0, 16'h0000, 0, 16'h0000, 0, 0, 16'd0,  1, 16'h0001);
        add(0, 16'h0000, 1, 16'hFFFF, 0, 0, 16'd0,  0, 16'h0000);
        add(0, 16'h0000, 0, 16'h0000, 0, 1, 16'd0,  0, 16'h0000);
        // mask_wr and irq_ack in the same cycle: both take effect.
        add(0, 16'h0000, 1, 16'h0000, 1, 0, 16'd0,  1, 16'h0000);
        add(0, 16'h0000, 0, 16'h0000, 0, 0, 16'd0,  0, 16'h0000);
        add(0, 16'h0000, 0, 16'h0000, 0, 0, 16'd0,  0, 16'h0000);
        add(0, 16'h0002, 0, 16'h0000, 0, 0, 16'd0,  1, 16'h0002);
        add(0, 16'h0000, 0, 16'h0000, 0, 0, 16'd0,  1, 16'h0002);
        add(0, 16'h0000, 0, 16'h0000, 0, 0, 16'd0,  0, 16'h0000);

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i], i);
        end

        // Unmask with input 1 already pending and a fresh edge on 15:
        // 15 first after one cycle, then 1 two cycles after its ack.
        irq_in = 16'h8000; mask_wr = 1'b1; mask_data = 16'hFFFF;
        @(posedge sysclk);
        #1;
        irq_in = '0; mask_wr = 1'b0;
        check16("seq_pending", 100, pending, 16'h8002);
        wait_valid(cyc);
        check16("seq_lat15", 101, 16'(cyc), 16'd1);
        check16("seq_code15", 102, irq_code, 16'd15);
        irq_ack = 1'b1;
        @(posedge sysclk);
        #1;
        irq_ack = 1'b0;
        check16("seq_valid_ack", 103, {15'd0, irq_valid}, 16'd0);
        wait_valid(cyc);
        check16("seq_lat1", 104, 16'(cyc), 16'd2);
        check16("seq_code1", 105, irq_code, 16'd1);
        irq_ack = 1'b1;
        @(posedge sysclk);
        #1;
        irq_ack = 1'b0;
        check16("seq_pending_end", 106, pending, 16'h0000);
        check16("sb_empty", 107, 16'(sb.size()), 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
